// File: rtl/mem_refill_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_refill_arbiter_pkg
// Brief    : Shared states, grant encoding and address helpers for the arbiter
// Revision : 1.0
// ============================================================================
package mem_refill_arbiter_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        I_BURST  = 2'd1,
        I_DONE   = 2'd2,
        D_ACCESS = 2'd3
    } state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_e;

    // Clears the byte-in-line offset so the burst always starts at word 0.
    function automatic logic [31:0] line_base(input logic [31:0] addr, input int line_words);
        logic [31:0] mask;
        mask = 32'(line_words * WORD_BYTES) - 32'd1;
        return addr & ~mask;
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_refill_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_refill_arbiter_if
// Brief    : Word-wide external memory request/acknowledge bus
// Revision : 1.0
// ============================================================================
interface mem_refill_arbiter_if;

    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [31:0] MemRData;
    logic        MemAck;

    modport master (
        output MemReq,
        output MemWe,
        output MemAddr,
        output MemWData,
        input  MemRData,
        input  MemAck
    );

    modport slave (
        input  MemReq,
        input  MemWe,
        input  MemAddr,
        input  MemWData,
        output MemRData,
        output MemAck
    );

endinterface
`default_nettype wire

// File: rtl/mem_refill_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Brief    : Two-requester round-robin arbiter; ties go opposite to last grant
// Revision : 1.0
// ============================================================================
module rr_arbiter2
    import mem_refill_arbiter_pkg::*;
(
    input  wire logic Clk,
    input  wire logic Rst_n,
    input  wire logic i_en,
    input  wire logic i_req_i,
    input  wire logic i_req_d,
    output logic      o_gnt_valid,
    output gnt_e      o_gnt
);

    gnt_e r_last;

    always_comb begin
        o_gnt_valid = i_en & (i_req_i | i_req_d);
        o_gnt       = GNT_I;
        if (i_req_i && i_req_d) begin
            o_gnt = (r_last == GNT_I) ? GNT_D : GNT_I;
        end else if (i_req_d) begin
            o_gnt = GNT_D;
        end
    end

    // Starting at GNT_I means the data side wins the first tie after reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_last <= GNT_I;
        end else if (o_gnt_valid) begin
            r_last <= o_gnt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_refill_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_refill_arbiter
// Brief    : Shares one memory port between I-line refills and D word accesses
//            Optional MEM_TIMEOUT_EN adds a per-word ack timeout with BusErr.
// Revision : 1.0
// ============================================================================
module mem_refill_arbiter
    import mem_refill_arbiter_pkg::*;
#(
    parameter int LINE_WORDS     = 4,
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  wire logic                          Clk,
    input  wire logic                          Rst_n,
    input  wire logic                          IMiss,
    input  wire logic [31:0]                   IMissAddr,
    output logic                               IRefillWe,
    output logic [$clog2(LINE_WORDS)-1:0]      IRefillIdx,
    output logic [31:0]                        IRefillData,
    output logic                               IRefillDone,
    output logic                               IStall,
    input  wire logic                          DReq,
    input  wire logic                          DWe,
    input  wire logic [31:0]                   DAddr,
    input  wire logic [31:0]                   DWData,
    output logic [31:0]                        DRData,
    output logic                               DAck,
    mem_refill_arbiter_if.master               mem,
    output logic                               BusErr
);

    localparam int                  c_IDX_W = $clog2(LINE_WORDS);
    localparam logic [c_IDX_W-1:0]  c_LAST  = c_IDX_W'(LINE_WORDS - 1);

    state_e               r_state;
    logic [31:0]          r_base;
    logic [c_IDX_W-1:0]   r_cnt;
    logic                 r_mem_req;
    logic                 r_mem_we;
    logic [31:0]          r_mem_addr;
    logic [31:0]          r_mem_wdata;
    logic                 r_refill_we;
    logic [c_IDX_W-1:0]   r_refill_idx;
    logic [31:0]          r_refill_data;
    logic                 r_refill_done;
    logic [31:0]          r_drdata;
    logic                 r_dack;

    logic                 w_arb_en;
    logic                 w_gnt_valid;
    gnt_e                 w_gnt;
    logic [31:0]          w_base;
    logic [c_IDX_W-1:0]   w_cnt_inc;
    logic [31:0]          w_next_off;

`ifdef MEM_TIMEOUT_EN
    localparam int                 c_WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT_CYCLES - 1);
    logic [c_WAIT_W-1:0]  r_wait;
    logic                 r_bus_err;
    assign BusErr = r_bus_err;
`else
    logic [31:0]          w_unused_timeout;
    assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
    assign BusErr           = 1'b0;
`endif

    // Grants are held off during the DAck cycle so a requester that is still
    // dropping DReq cannot be re-served; this gives the mandatory IDLE gap.
    assign w_arb_en   = (r_state == IDLE) && !r_dack;
    assign w_base     = line_base(IMissAddr, LINE_WORDS);
    assign w_cnt_inc  = r_cnt + c_IDX_W'(1);
    assign w_next_off = {{(30 - c_IDX_W){1'b0}}, w_cnt_inc, 2'b00};

    rr_arbiter2 u_rr_arbiter2 (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .i_en        (w_arb_en),
        .i_req_i     (IMiss),
        .i_req_d     (DReq),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt       (w_gnt)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state       <= IDLE;
            r_base        <= '0;
            r_cnt         <= '0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_refill_we   <= 1'b0;
            r_refill_idx  <= '0;
            r_refill_data <= '0;
            r_refill_done <= 1'b0;
            r_drdata      <= '0;
            r_dack        <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_wait        <= '0;
            r_bus_err     <= 1'b0;
`endif
        end else begin
            r_refill_we   <= 1'b0;
            r_refill_done <= 1'b0;
            r_dack        <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
`ifdef MEM_TIMEOUT_EN
                        r_wait <= '0;
`endif
                        r_mem_req <= 1'b1;
                        if (w_gnt == GNT_I) begin
                            r_state    <= I_BURST;
                            r_base     <= w_base;
                            r_cnt      <= '0;
                            r_mem_addr <= w_base;
                            r_mem_we   <= 1'b0;
                        end else begin
                            r_state     <= D_ACCESS;
                            r_mem_addr  <= word_align(DAddr);
                            r_mem_we    <= DWe;
                            r_mem_wdata <= DWData;
                        end
                    end
                end

                I_BURST: begin
                    if (mem.MemAck) begin
`ifdef MEM_TIMEOUT_EN
                        r_wait <= '0;
`endif
                        r_refill_we   <= 1'b1;
                        r_refill_idx  <= r_cnt;
                        r_refill_data <= mem.MemRData;
                        r_cnt         <= w_cnt_inc;
                        if (r_cnt == c_LAST) begin
                            r_state       <= I_DONE;
                            r_refill_done <= 1'b1;
                            r_mem_req     <= 1'b0;
                        end else begin
                            r_mem_addr <= r_base + w_next_off;
                        end
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (r_wait == c_WAIT_LAST) begin
                        r_state       <= I_DONE;
                        r_refill_done <= 1'b1;
                        r_mem_req     <= 1'b0;
                        r_bus_err     <= 1'b1;
                    end else begin
                        r_wait <= r_wait + c_WAIT_W'(1);
                    end
`endif
                end

                I_DONE: begin
                    r_state <= IDLE;
                end

                D_ACCESS: begin
                    if (mem.MemAck) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_dack    <= 1'b1;
                        if (!r_mem_we) begin
                            r_drdata <= mem.MemRData;
                        end
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (r_wait == c_WAIT_LAST) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_dack    <= 1'b1;
                        r_drdata  <= '0;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_wait <= r_wait + c_WAIT_W'(1);
                    end
`endif
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem.MemReq   = r_mem_req;
    assign mem.MemWe    = r_mem_we;
    assign mem.MemAddr  = r_mem_addr;
    assign mem.MemWData = r_mem_wdata;

    assign IRefillWe    = r_refill_we;
    assign IRefillIdx   = r_refill_idx;
    assign IRefillData  = r_refill_data;
    assign IRefillDone  = r_refill_done;
    assign IStall       = IMiss & ~r_refill_done;
    assign DRData       = r_drdata;
    assign DAck         = r_dack;

endmodule
`default_nettype wire

// File: tb/tb_mem_refill_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_refill_arbiter
// Brief    : Directed self-checking bench with a behavioural memory responder
// Revision : 1.0
// ============================================================================
module tb_mem_refill_arbiter;

    localparam int LW = 4;
`ifdef MEM_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        IMiss = 1'b0;
    logic [31:0] IMissAddr = '0;
    logic        IRefillWe;
    logic [1:0]  IRefillIdx;
    logic [31:0] IRefillData;
    logic        IRefillDone;
    logic        IStall;
    logic        DReq = 1'b0;
    logic        DWe = 1'b0;
    logic [31:0] DAddr = '0;
    logic [31:0] DWData = '0;
    logic [31:0] DRData;
    logic        DAck;
    logic        BusErr;

    mem_refill_arbiter_if bus();

    mem_refill_arbiter #(.LINE_WORDS(LW), .TIMEOUT_CYCLES(TO)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .IMiss(IMiss), .IMissAddr(IMissAddr),
        .IRefillWe(IRefillWe), .IRefillIdx(IRefillIdx), .IRefillData(IRefillData),
        .IRefillDone(IRefillDone), .IStall(IStall),
        .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData),
        .DRData(DRData), .DAck(DAck),
        .mem(bus.master), .BusErr(BusErr)
    );

    always #5 Clk = ~Clk;

    int tests_run = 0;
    int tests_failed = 0;
    int cycle = 0;
    always @(posedge Clk) cycle++;

    // Memory responder: acks after ack_delay idle request cycles.
    int          ack_delay = 2;
    bit          ack_en = 1'b1;
    int          wait_cnt = 0;
    logic [31:0] store [logic [31:0]];
    logic [31:0] ack_addr_q [$];
    logic        ack_we_q [$];
    int          last_ack_cycle = 0;

    initial begin
        bus.MemAck   = 1'b0;
        bus.MemRData = '0;
    end

    always @(negedge Clk) begin
        bus.MemAck = 1'b0;
        if (!Rst_n) begin
            wait_cnt = 0;
        end else if (bus.MemReq && ack_en) begin
            if (wait_cnt >= ack_delay) begin
                bus.MemAck = 1'b1;
                if (bus.MemWe) begin
                    store[bus.MemAddr] = bus.MemWData;
                    bus.MemRData = 32'h1234_5678;
                end else if (store.exists(bus.MemAddr)) begin
                    bus.MemRData = store[bus.MemAddr];
                end else begin
                    bus.MemRData = bus.MemAddr ^ 32'h5A5A_0000;
                end
                ack_addr_q.push_back(bus.MemAddr);
                ack_we_q.push_back(bus.MemWe);
                last_ack_cycle = cycle;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Output monitor
    logic [1:0]  ref_idx_q [$];
    logic [31:0] ref_data_q [$];
    int done_cnt = 0, dack_cnt = 0, done_cycle = 0, dack_cycle = 0;
    logic [31:0] dack_rdata = '0;

    always @(negedge Clk) begin
        if (IRefillWe) begin
            ref_idx_q.push_back(IRefillIdx);
            ref_data_q.push_back(IRefillData);
        end
        if (IRefillDone) begin
            done_cnt++;
            done_cycle = cycle;
        end
        if (DAck) begin
            dack_cnt++;
            dack_cycle = cycle;
            dack_rdata = DRData;
        end
    end

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic clear_logs();
        ack_addr_q.delete();
        ack_we_q.delete();
        ref_idx_q.delete();
        ref_data_q.delete();
        done_cnt = 0;
        dack_cnt = 0;
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((IMiss || DReq) && n < budget) begin
            tick();
            n++;
            if (DAck) DReq = 1'b0;
            if (IRefillDone) IMiss = 1'b0;
        end
        tests_run++;
        if (IMiss || DReq) begin
            tests_failed++;
            $display("FAIL %s_complete: IMiss=%0b DReq=%0b after %0d cycles, required both served", tag, IMiss, DReq, n);
            IMiss = 1'b0;
            DReq  = 1'b0;
        end
        repeat (3) tick();
    endtask

    task automatic check_acks(input string tag, input logic [31:0] exp_addr [], input int exp_we_last);
        tests_run++;
        if (ack_addr_q.size() !== exp_addr.size()) begin
            tests_failed++;
            $display("FAIL %s_ack_count: got %0d, required %0d", tag, ack_addr_q.size(), exp_addr.size());
        end else begin
            for (int i = 0; i < exp_addr.size(); i++) begin
                tests_run++;
                if (ack_addr_q[i] !== exp_addr[i] || ack_we_q[i] !== ((i == exp_addr.size() - 1) ? exp_we_last[0] : 1'b0)) begin
                    tests_failed++;
                    $display("FAIL %s_ack%0d: addr=%h we=%0b, required addr=%h", tag, i, ack_addr_q[i], ack_we_q[i], exp_addr[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        repeat (2) tick();
        tests_run++;
        if ({bus.MemReq, bus.MemWe, IRefillWe, IRefillDone, DAck, BusErr} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: {Req,We,RWe,Done,DAck,Err}=%b, required 000000",
                     {bus.MemReq, bus.MemWe, IRefillWe, IRefillDone, DAck, BusErr});
        end
        tests_run++;
        if (bus.MemAddr !== 32'h0 || DRData !== 32'h0 || IRefillData !== 32'h0 || IRefillIdx !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_data: MemAddr=%h DRData=%h IRefillData=%h, required 0", bus.MemAddr, DRData, IRefillData);
        end
        IMiss = 1'b1;
        #1;
        tests_run++;
        if (IStall !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_istall_hi: got %b, required 1", IStall);
        end
        IMiss = 1'b0;
        #1;
        tests_run++;
        if (IStall !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_istall_lo: got %b, required 0", IStall);
        end
        tick();
        Rst_n = 1'b1;
        clear_logs();
        repeat (2) tick();
    endtask

    task automatic test_refill();
        int n;
        bit seen;
        logic [31:0] exp_addr [];
        clear_logs();
        ack_delay = 2;
        IMissAddr = 32'h0000_0104;
        IMiss = 1'b1;
        #1;
        tests_run++;
        if (IStall !== 1'b1) begin
            tests_failed++;
            $display("FAIL refill_stall_req: got %b, required 1", IStall);
        end
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            tick();
            n++;
            if (IRefillDone) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL refill_done_seen: no IRefillDone in %0d cycles, required one", n);
        end
        tests_run++;
        if (IStall !== 1'b0 || IRefillWe !== 1'b1 || IRefillIdx !== 2'd3) begin
            tests_failed++;
            $display("FAIL refill_done_cycle: IStall=%b We=%b Idx=%0d, required 0,1,3", IStall, IRefillWe, IRefillIdx);
        end
        IMiss = 1'b0;
        tick();
        tests_run++;
        if (IStall !== 1'b0 || IRefillDone !== 1'b0) begin
            tests_failed++;
            $display("FAIL refill_after_done: IStall=%b Done=%b, required 0,0", IStall, IRefillDone);
        end
        repeat (4) tick();
        tests_run++;
        if (done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL refill_done_count: got %0d, required 1", done_cnt);
        end
        exp_addr = '{32'h100, 32'h104, 32'h108, 32'h10C};
        check_acks("refill", exp_addr, 0);
        tests_run++;
        if (ref_idx_q.size() !== 4) begin
            tests_failed++;
            $display("FAIL refill_we_count: got %0d, required 4", ref_idx_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (ref_idx_q[i] !== 2'(i) || ref_data_q[i] !== ((32'h100 + 32'(4 * i)) ^ 32'h5A5A_0000)) begin
                    tests_failed++;
                    $display("FAIL refill_word%0d: idx=%0d data=%h, required idx=%0d data=%h", i, ref_idx_q[i], ref_data_q[i],
                             i, (32'h100 + 32'(4 * i)) ^ 32'h5A5A_0000);
                end
            end
        end
    endtask

    task automatic test_store_load();
        logic [31:0] exp_addr [];
        clear_logs();
        DWe = 1'b1; DAddr = 32'h2003; DWData = 32'hDEAD_BEEF; DReq = 1'b1;
        run_until_idle("store", 100);
        exp_addr = '{32'h2000};
        check_acks("store", exp_addr, 1);
        tests_run++;
        if (dack_cnt !== 1 || dack_cycle - last_ack_cycle !== 1 || DRData !== 32'h0) begin
            tests_failed++;
            $display("FAIL store_ack: count=%0d lat=%0d DRData=%h, required 1,1,00000000",
                     dack_cnt, dack_cycle - last_ack_cycle, DRData);
        end
        clear_logs();
        DWe = 1'b0; DAddr = 32'h2000; DReq = 1'b1;
        run_until_idle("load", 100);
        check_acks("load", exp_addr, 0);
        tests_run++;
        if (dack_rdata !== 32'hDEAD_BEEF || DRData !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL load_data: got %h, required deadbeef", dack_rdata);
        end
    endtask

    task automatic test_tie();
        logic [31:0] exp_addr [];
        Rst_n = 1'b0;
        repeat (2) tick();
        clear_logs();
        ack_delay = 1;
        IMissAddr = 32'h300; DAddr = 32'h400; DWe = 1'b0;
        Rst_n = 1'b1; IMiss = 1'b1; DReq = 1'b1;
        run_until_idle("tie1", 200);
        exp_addr = '{32'h400, 32'h300, 32'h304, 32'h308, 32'h30C};
        check_acks("tie1", exp_addr, 0);
        tests_run++;
        if (dack_rdata !== 32'h5A5A_0400 || !(dack_cycle < done_cycle)) begin
            tests_failed++;
            $display("FAIL tie1_order: rdata=%h dack@%0d done@%0d, required 5a5a0400 and D first", dack_rdata, dack_cycle, done_cycle);
        end
        DWe = 1'b1; DAddr = 32'h500; DWData = 32'h1; DReq = 1'b1;
        run_until_idle("tie_dsolo", 100);
        clear_logs();
        IMissAddr = 32'h600; DAddr = 32'h700; DWe = 1'b0;
        IMiss = 1'b1; DReq = 1'b1;
        run_until_idle("tie2", 200);
        exp_addr = '{32'h600, 32'h604, 32'h608, 32'h60C, 32'h700};
        check_acks("tie2", exp_addr, 0);
        tests_run++;
        if (DRData !== 32'h5A5A_0700 || !(done_cycle < dack_cycle)) begin
            tests_failed++;
            $display("FAIL tie2_order: rdata=%h done@%0d dack@%0d, required 5a5a0700 and I first", DRData, done_cycle, dack_cycle);
        end
    endtask

    task automatic test_reset_mid_burst();
        int n;
        clear_logs();
        ack_delay = 2;
        IMissAddr = 32'h804; IMiss = 1'b1;
        n = 0;
        while (ack_addr_q.size() < 2 && n < 100) begin
            tick();
            n++;
        end
        tick();
        Rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.MemReq !== 1'b0 || IRefillWe !== 1'b0 || IStall !== 1'b1 || ack_addr_q.size() !== 2) begin
            tests_failed++;
            $display("FAIL midrst_abort: MemReq=%b We=%b IStall=%b acks=%0d, required 0,0,1,2",
                     bus.MemReq, IRefillWe, IStall, ack_addr_q.size());
        end
        repeat (3) tick();
        tests_run++;
        if (done_cnt !== 0 || IRefillDone !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_no_done: done_cnt=%0d, required 0", done_cnt);
        end
        clear_logs();
        Rst_n = 1'b1;
        run_until_idle("midrst", 200);
        tests_run++;
        if (ack_addr_q.size() !== 4 || ack_addr_q[0] !== 32'h800 || ref_idx_q.size() !== 4 || ref_idx_q[0] !== 2'd0 || done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL midrst_restart: acks=%0d first=%h wes=%0d done=%0d, required 4,00000800,4,1",
                     ack_addr_q.size(), ack_addr_q[0], ref_idx_q.size(), done_cnt);
        end
    endtask

    task automatic test_drop_and_queue();
        int n;
        logic [31:0] exp_addr [];
        clear_logs();
        ack_delay = 1;
        IMissAddr = 32'h90C; IMiss = 1'b1;
        n = 0;
        while (ack_addr_q.size() < 1 && n < 100) begin
            tick();
            n++;
        end
        IMiss = 1'b0;
        DWe = 1'b1; DAddr = 32'hA04; DWData = 32'hCAFE_F00D; DReq = 1'b1;
        run_until_idle("drop", 200);
        exp_addr = '{32'h900, 32'h904, 32'h908, 32'h90C, 32'hA04};
        check_acks("drop", exp_addr, 1);
        tests_run++;
        if (ref_idx_q.size() !== 4 || done_cnt !== 1 || !(done_cycle < dack_cycle)) begin
            tests_failed++;
            $display("FAIL drop_line: wes=%0d done=%0d done@%0d dack@%0d, required 4,1 and done before dack",
                     ref_idx_q.size(), done_cnt, done_cycle, dack_cycle);
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        clear_logs();
        ack_delay = 0;
        IMissAddr = 32'hB08; IMiss = 1'b1;
        c0 = cycle;
        run_until_idle("b2b", 100);
        tests_run++;
        if (done_cycle - c0 !== LW + 1) begin
            tests_failed++;
            $display("FAIL b2b_latency: got %0d cycles, required %0d", done_cycle - c0, LW + 1);
        end
        tests_run++;
        if (ref_data_q.size() !== 4 || ref_data_q[0] !== 32'h5A5A_0B00 || ref_data_q[3] !== 32'h5A5A_0B0C) begin
            tests_failed++;
            $display("FAIL b2b_data: n=%0d d0=%h d3=%h, required 4,5a5a0b00,5a5a0b0c",
                     ref_data_q.size(), ref_data_q[0], ref_data_q[3]);
        end
        ack_delay = 1;
    endtask

    task automatic test_timeout();
`ifdef MEM_TIMEOUT_EN
        int n, req_cycles;
        bit seen;
        clear_logs();
        ack_en = 1'b0;
        DWe = 1'b0; DAddr = 32'hC00; DReq = 1'b1;
        n = 0; req_cycles = 0; seen = 1'b0;
        while (!seen && n < 60) begin
            tick();
            n++;
            if (bus.MemReq) req_cycles++;
            if (DAck) begin
                seen = 1'b1;
                DReq = 1'b0;
            end
        end
        tests_run++;
        if (!seen || req_cycles !== TO || DRData !== 32'h0 || BusErr !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_d: dack=%0b req_cycles=%0d DRData=%h BusErr=%b, required 1,%0d,00000000,1",
                     seen, req_cycles, DRData, BusErr, TO);
        end
        DReq = 1'b0;
        IMissAddr = 32'hD00; IMiss = 1'b1;
        repeat (3) tick();
        run_until_idle("timeout_i", 60);
        tests_run++;
        if (done_cnt !== 1 || ref_idx_q.size() !== 0 || bus.MemReq !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_i: done=%0d wes=%0d MemReq=%b, required 1,0,0", done_cnt, ref_idx_q.size(), bus.MemReq);
        end
        ack_en = 1'b1;
        DWe = 1'b1; DAddr = 32'hC04; DWData = 32'h55; DReq = 1'b1;
        run_until_idle("timeout_after", 100);
        tests_run++;
        if (BusErr !== 1'b1 || dack_cnt !== 2) begin
            tests_failed++;
            $display("FAIL timeout_sticky: BusErr=%b dack_cnt=%0d, required 1,2", BusErr, dack_cnt);
        end
`else
        tests_run++;
        if (BusErr !== 1'b0) begin
            tests_failed++;
            $display("FAIL buserr_tied: got %b, required 0", BusErr);
        end
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required termination");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_refill();
        test_store_load();
        test_tie();
        test_reset_mid_burst();
        test_drop_and_queue();
        test_back_to_back();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_refill_arbiter.md
Name: mem_refill_arbiter

Overview:
Shares one external word-wide memory port between the fetch stage's instruction-miss refill and the data stage's single-word load/store.
- An I-side miss triggers a LINE_WORDS-word line refill into instruction memory.
- A D-side request triggers one read or write.
- Round-robin arbitration on ties; stalls fetch while a refill is pending or in progress.

Parameters:
LINE_WORDS, 4, words per instruction line (power of two, >=2)
TIMEOUT_CYCLES, 255, max wait for MemAck per word (used only with MEM_TIMEOUT_EN)

Ports:
Clk  in  1  clock, rising edge
Rst_n  in  1  asynchronous active-low reset
IMiss  in  1  fetch miss request; held high until IRefillDone
IMissAddr  in  32  miss address, byte address
IRefillWe  out  1  one-cycle pulse: IRefillData valid for word IRefillIdx
IRefillIdx  out  $clog2(LINE_WORDS)  word index within line
IRefillData  out  32  refill word
IRefillDone  out  1  one-cycle pulse: line complete
IStall  out  1  PC/fetch stall
DReq  in  1  data request; held high until DAck
DWe  in  1  1=store, 0=load
DAddr  in  32  data byte address
DWData  in  32  store data
DRData  out  32  load data
DAck  out  1  one-cycle completion pulse
MemReq  out  1  memory request, held until MemAck
MemWe  out  1  memory write enable
MemAddr  out  32  memory byte address, word aligned
MemWData  out  32  memory write data
MemRData  in  32  memory read data, valid with MemAck
MemAck  in  1  per-word acknowledge
BusErr  out  1  sticky timeout error (MEM_TIMEOUT_EN only, else 0)

Behaviour:
- Reset (async, Rst_n=0):
  - State=IDLE; LastGrant=I.
  - All outputs 0 except IStall, which equals IMiss combinationally.
  - A reset mid-burst aborts with no Done or Ack pulse.
- States: IDLE, I_BURST, I_DONE, D_ACCESS.
- IDLE arbitration:
  - Only IMiss -> I_BURST.
  - Only DReq -> D_ACCESS.
  - Both -> grant the opposite of LastGrant. After reset, D wins the first tie.
  - LastGrant updates at grant.
  - Addresses and data are latched at grant; later input changes are ignored.
- I_BURST:
  - Base = IMissAddr with low log2(LINE_WORDS)+2 bits cleared.
  - Cnt = 0; MemAddr = Base + 4*Cnt; MemReq=1; MemWe=0.
  - On each MemAck: next cycle IRefillWe=1, IRefillIdx=Cnt, IRefillData=registered MemRData; Cnt++.
  - MemReq stays high across words. The next address appears the cycle after MemAck; back-to-back acks are legal.
  - Ack on Cnt=LINE_WORDS-1 -> I_DONE.
- I_DONE: one cycle; IRefillDone=1 (coincides with the last IRefillWe); then IDLE.
- D_ACCESS:
  - MemReq=1; MemWe=DWe; MemAddr = DAddr with bits[1:0] cleared; MemWData=DWData.
  - On MemAck: next cycle DAck=1 and DRData=registered MemRData (loads; holds its value for stores); then IDLE.
- Non-abortable transfers:
  - A burst is never aborted by IMiss falling; the line always completes.
  - A D access is never preempted by IMiss.
- IStall = IMiss & ~IRefillDone.
- Grants and requests in the same cycle: an IMiss rising in the cycle D is granted waits. At the earliest it is granted in the IDLE cycle after DAck.
- One IDLE cycle minimum between transactions.
- Memory latency is unbounded unless MEM_TIMEOUT_EN.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - A per-word wait counter resets on every MemAck and on every grant.
  - If it reaches TIMEOUT_CYCLES with no MemAck, drop MemReq, set BusErr (sticky until reset), and return to IDLE.
  - Still issue the requester's terminating pulse (IRefillDone or DAck) so neither requester hangs. DRData is 0 in this case.
- Undefined: no counter; BusErr tied 0; waits forever.

Decomposition:
- Shared package: state enum (IDLE/I_BURST/I_DONE/D_ACCESS), grant encoding (GNT_I/GNT_D), WORD_BYTES=4.
- One sub-module: rr_arbiter2, a 2-requester round-robin with LastGrant register.

Test Plan:
1. IMiss=1, IMissAddr=0x0000_0104, MemAck after 2 cycles per word -> MemAddr 0x100, 0x104, 0x108, 0x10C; four IRefillWe with Idx 0..3; one IRefillDone; IStall low the cycle after Done.
2. DReq store, DAddr=0x2003, DWData=0xDEADBEEF -> MemAddr=0x2000, MemWe=1, DAck one cycle after MemAck; load at 0x2000 returns 0xDEADBEEF.
3. IMiss and DReq both rise in the first cycle after reset -> D served first, then I burst; a second simultaneous pair -> I first.
4. Rst_n low during word 2 of a burst -> MemReq=0 immediately; no IRefillDone; a new IMiss after reset restarts at word 0.
5. IMiss drops mid-burst -> all LINE_WORDS words still written; DReq arriving mid-burst is served after IRefillDone.
6. With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, MemAck never asserted -> MemReq drops after 8 cycles; BusErr=1 and sticky; DAck pulse with DRData=0.
